// File: rtl/perf_halt_monitor.sv
// Run-control and performance counters at the write-back end of the pipeline.
// Counts cycles/retired/stalled instructions, drains on halt, then freezes.
module perf_halt_monitor #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             stall,
  input  logic             halt_req,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             stop,
  output logic             done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0]       DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_inst;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_stall;
  logic             r_stop;
  logic             r_done;

  logic w_inst_sat;
  logic w_cycle_sat;
  logic w_stall_sat;

  // Counters saturate at all-ones rather than wrapping.
  assign w_inst_sat  = &r_inst;
  assign w_cycle_sat = &r_cycle;
  assign w_stall_sat = &r_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_inst      <= '0;
      r_cycle     <= '0;
      r_stall     <= '0;
      r_stop      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!w_cycle_sat)            r_cycle <= r_cycle + CNT_ONE;
          if (wb_valid && !w_inst_sat) r_inst  <= r_inst + CNT_ONE;
          if (stall && !w_stall_sat)   r_stall <= r_stall + CNT_ONE;
          if (halt_req) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
            r_stop      <= 1'b1;
          end
        end
        S_DRAIN: begin
          // In-flight instructions still retire, including on the final DRAIN edge.
          if (wb_valid && !w_inst_sat) r_inst <= r_inst + CNT_ONE;
          if (r_drain_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_RUN;
          r_stop  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign inst_count  = r_inst;
  assign cycle_count = r_cycle;
  assign stall_count = r_stall;
  assign stop        = r_stop;
  assign done        = r_done;

endmodule

// File: tb/tb_perf_halt_monitor.sv
// Bench for perf_halt_monitor: a 32-bit and a 4-bit instance share stimulus and are
// checked against an edge-index model (halt edge N, drain window N..N+D).
module tb_perf_halt_monitor;

  localparam int D = 5;

  logic clk = 1'b0;
  logic rst, wb_valid, stall, halt_req;
  logic [31:0] inst_w, cyc_w, stl_w;
  logic [3:0]  inst_n, cyc_n, stl_n;
  logic stop_w, done_w, stop_n, done_n;

  int checks   = 0;
  int failures = 0;

  // Model: k = edges since reset, n = halt edge (-1 if none yet).
  longint m_k, m_n, m_inst, m_stall;

  perf_halt_monitor #(.CNT_W(32), .DRAIN_CYCLES(D)) dut_w (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .stall(stall), .halt_req(halt_req),
    .inst_count(inst_w), .cycle_count(cyc_w), .stall_count(stl_w),
    .stop(stop_w), .done(done_w)
  );

  perf_halt_monitor #(.CNT_W(4), .DRAIN_CYCLES(D)) dut_n (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .stall(stall), .halt_req(halt_req),
    .inst_count(inst_n), .cycle_count(cyc_n), .stall_count(stl_n),
    .stop(stop_n), .done(done_n)
  );

  always #5 clk = ~clk;

  function automatic longint sat(longint x, longint cap);
    return (x > cap) ? cap : x;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit wb, input bit st, input bit h);
    if (r) begin
      m_k = 0; m_n = -1; m_inst = 0; m_stall = 0;
    end else begin
      m_k++;
      if (m_n < 0) begin
        if (wb) m_inst++;
        if (st) m_stall++;
        if (h)  m_n = m_k;
      end else if (m_k <= m_n + D) begin
        if (wb) m_inst++;
      end
    end
  endtask

  task automatic check_model();
    longint cyc;
    bit     e_stop, e_done;
    cyc    = (m_n < 0) ? m_k : m_n;
    e_stop = (m_n >= 0);
    e_done = (m_n >= 0) && (m_k >= m_n + D);
    chk("w.inst",  inst_w, sat(m_inst, 64'hFFFF_FFFF));
    chk("w.cycle", cyc_w,  sat(cyc, 64'hFFFF_FFFF));
    chk("w.stall", stl_w,  sat(m_stall, 64'hFFFF_FFFF));
    chk("w.stop",  stop_w, e_stop);
    chk("w.done",  done_w, e_done);
    chk("n.inst",  inst_n, sat(m_inst, 15));
    chk("n.cycle", cyc_n,  sat(cyc, 15));
    chk("n.stall", stl_n,  sat(m_stall, 15));
    chk("n.stop",  stop_n, e_stop);
    chk("n.done",  done_n, e_done);
  endtask

  // Drive one edge's inputs, clock it, then compare all outputs 1 time unit later.
  task automatic step(input bit r, input bit wb, input bit st, input bit h);
    rst = r; wb_valid = wb; stall = st; halt_req = h;
    @(posedge clk);
    model_edge(r, wb, st, h);
    #1;
    check_model();
  endtask

  typedef struct {
    bit r, wb, st, h;
    int inst, cyc, stl;
    bit stop, done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b1; wb_valid = 1'b0; stall = 1'b0; halt_req = 1'b0;
    m_k = 0; m_n = -1; m_inst = 0; m_stall = 0;

    // Short run: halt at edge 3, done after edge 8, then frozen.
    tbl[0]  = '{1,1,1,1, 0,0,0, 0,0};
    tbl[1]  = '{1,0,1,0, 0,0,0, 0,0};
    tbl[2]  = '{0,1,0,0, 1,1,0, 0,0};
    tbl[3]  = '{0,1,1,0, 2,2,1, 0,0};
    tbl[4]  = '{0,0,1,1, 2,3,2, 1,0};
    tbl[5]  = '{0,1,1,0, 3,3,2, 1,0};
    tbl[6]  = '{0,1,0,1, 4,3,2, 1,0};
    tbl[7]  = '{0,0,0,0, 4,3,2, 1,0};
    tbl[8]  = '{0,1,0,0, 5,3,2, 1,0};
    tbl[9]  = '{0,1,0,0, 6,3,2, 1,1};
    tbl[10] = '{0,1,1,1, 6,3,2, 1,1};

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].wb, tbl[i].st, tbl[i].h);
      chk("tbl.inst",  inst_w, tbl[i].inst);
      chk("tbl.cycle", cyc_w,  tbl[i].cyc);
      chk("tbl.stall", stl_w,  tbl[i].stl);
      chk("tbl.stop",  stop_w, tbl[i].stop);
      chk("tbl.done",  done_w, tbl[i].done);
    end

    // Basic count: wb_valid every edge, halt at edge 20.
    step(1, 1, 1, 1);
    step(1, 0, 1, 0);
    chk("rst.stop", stop_w, 0);
    chk("rst.done", done_w, 0);
    for (int e = 1; e <= 19; e++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("basic.stop20",  stop_w, 1);
    chk("basic.cycle20", cyc_w, 20);
    for (int e = 21; e <= 24; e++) step(0, 1, 0, 0);
    chk("basic.done24", done_w, 0);
    step(0, 1, 0, 0);
    chk("basic.done25", done_w, 1);
    chk("basic.inst25", inst_w, 25);
    step(0, 1, 0, 0);
    chk("basic.inst26", inst_w, 25);

    // Stalls on 7 of 30 RUN edges, stall held through DRAIN, then post-done freeze.
    step(1, 0, 0, 0);
    for (int e = 1; e <= 30; e++)
      step(0, 1, (e == 2 || e == 5 || e == 9 || e == 14 || e == 15 || e == 22 || e == 29), (e == 30));
    for (int e = 0; e < D; e++) step(0, 1, 1, 0);
    chk("stall.count", stl_w, 7);
    chk("stall.done",  done_w, 1);
    for (int e = 0; e < 20; e++) begin
      step(0, 1'($urandom), 1'($urandom), 1'($urandom));
      chk("freeze.cycle", cyc_w, 30);
      chk("freeze.inst",  inst_w, 35);
      chk("freeze.stall", stl_w, 7);
      chk("freeze.done",  done_w, 1);
    end

    // Saturation: 20 edges of wb_valid, no halt.
    step(1, 0, 0, 0);
    for (int e = 1; e <= 20; e++) step(0, 1, 0, 0);
    chk("sat.n.cycle", cyc_n, 15);
    chk("sat.n.inst",  inst_n, 15);
    chk("sat.w.cycle", cyc_w, 20);

    // Reset mid-DRAIN, then a fresh run halting at edge 3.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("mid.inst",  inst_w, 0);
    chk("mid.cycle", cyc_w, 0);
    chk("mid.stop",  stop_w, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("mid.cycle3", cyc_w, 3);
    for (int e = 4; e <= 7; e++) step(0, 0, 0, 0);
    chk("mid.done7", done_w, 0);
    step(0, 0, 0, 0);
    chk("mid.done8", done_w, 1);

    // Random runs, occasional reset (can land mid-DRAIN).
    for (int run = 0; run < 8; run++) begin
      step(1, 1'($urandom), 1'($urandom), 1'($urandom));
      for (int e = 0; e < 60; e++)
        step(($urandom_range(0, 99) == 0),
             1'($urandom), ($urandom_range(0, 3) == 0),
             (run != 0) && ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_halt_monitor.md
# perf_halt_monitor

Run-control and performance-counter block inside `dataPath`, sitting at the write-back end of the ARM32 five-stage pipeline. It produces the `inst_count` and `stop` outputs that the top-level bench consumes. It counts cycles, retired instructions and stall cycles. On the fetch-side halt request it drains the in-flight pipeline for a fixed number of cycles, then freezes all counters and raises `done`. This lets CPI be read as `cycle_count / inst_count` without bench-side drain loops.

## Interface
Parameters:
- `CNT_W`, 32, width of all counters.
- `DRAIN_CYCLES`, 5, clock edges spent in DRAIN after halt. Legal range is 1 to 255. It equals the pipeline depth so the last fetched instruction reaches WB.

Ports:
- `clk`, in, 1, single clock. All state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `wb_valid`, in, 1, a non-bubble instruction completes WB this cycle.
- `stall`, in, 1, the hazard unit froze IF/ID this cycle.
- `halt_req`, in, 1, fetch reached end of program. It is level and may stay high.
- `inst_count`, out, `CNT_W`, retired instruction count.
- `cycle_count`, out, `CNT_W`, cycles spent in RUN.
- `stall_count`, out, `CNT_W`, stalled cycles while in RUN.
- `stop`, out, 1, high in DRAIN and DONE. It tells fetch to stop issuing.
- `done`, out, 1, high only in DONE. All counters are final.

## Operation
- State machine: RUN, DRAIN, DONE. Encoding is free.
- On reset, state becomes RUN and `drain_cnt` becomes 0. All of `inst_count`, `cycle_count`, `stall_count`, `stop` and `done` become 0.
- **RUN:**
  - `cycle_count` increments every edge.
  - `inst_count` increments when `wb_valid` is high.
  - `stall_count` increments when `stall` is high.
  - If `halt_req` is high, go to DRAIN and load `drain_cnt` with `DRAIN_CYCLES-1`. The counter updates above still apply on that same edge.
- **DRAIN:**
  - `cycle_count` and `stall_count` are frozen.
  - `inst_count` still increments on `wb_valid`, so in-flight instructions are counted.
  - If `drain_cnt` is 0, go to DONE. Otherwise decrement `drain_cnt`.
  - `halt_req` is ignored.
- **DONE:**
  - Terminal until `rst`.
  - All counters are frozen.
  - `wb_valid`, `stall` and `halt_req` are ignored.
- All counters saturate at all-ones and never wrap.
- `stop` and `done` are registered, decoded from the state register, and glitch-free.
- `rst` overrides everything on any edge, including mid-DRAIN. The next edge with `rst` low counts as RUN cycle 1.

## Timing
- Let edge k be the k-th rising edge with `rst` low after reset.
- If `halt_req` is first sampled high at edge N:
  - `stop` goes high after edge N.
  - `cycle_count` reads N after edge N.
  - `done` goes high after edge N+`DRAIN_CYCLES`.
- Update latency from input to counter output is one cycle.
- `wb_valid` sampled at edge N+`DRAIN_CYCLES` (the DRAIN→DONE edge) is counted.
- `wb_valid` sampled after that edge is not counted.
- If `halt_req` is high on the first edge after reset, it is accepted: `cycle_count` becomes 1.
- `halt_req` and `wb_valid` high on the same edge are both honoured.

## Test plan
- **Reset values:** hold `rst` for 2 edges with inputs toggling. All outputs must read 0, and `stop` and `done` must be low.
- **Basic count:** `DRAIN_CYCLES`=5. Give `wb_valid`=1 for edges 1–20, then raise `halt_req` at edge 20.
  - `stop` is high after edge 20 and `done` is high after edge 25.
  - `cycle_count`=20.
  - `inst_count`=25 with `wb_valid` held high through edge 25.
- **Stalls:** over 30 RUN edges, drive `stall` high on 7 of them, then halt.
  - `stall_count`=7.
  - `stall` asserted during DRAIN must not change it.
- **Post-done freeze:** after `done`, toggle all inputs for 20 edges. No output may change.
- **Saturation:** with `CNT_W`=4, run 20 edges with `wb_valid`=1 and no halt. `cycle_count` and `inst_count` hold at 15.
- **Reset mid-DRAIN:** assert `rst` 2 edges after halt.
  - All outputs return to 0.
  - A new run with halt at edge 3 gives `cycle_count`=3, and `done` is high after edge 8.
